// File: rtl/corelet_ctrl_pkg.sv
// Shared definitions for the corelet controller and its bench:
// instruction bit positions and the run-sequencer state encoding.
package corelet_ctrl_pkg;

    localparam int INST_W  = 9;
    localparam int I_KLOAD = 0;
    localparam int I_EXEC  = 1;
    localparam int I_L0WR  = 2;
    localparam int I_L0RD  = 3;
    localparam int I_IFRD  = 4;
    localparam int I_IFWR  = 5;
    localparam int I_OFRD  = 6;
    localparam int I_ACC   = 7;
    localparam int I_RELU  = 8;

    typedef enum logic [2:0] {
        IDLE, W_LOAD, K_LOAD, K_FLUSH, A_LOAD, EXEC, DRAIN, NEXT
    } state_e;

endpackage

// File: rtl/corelet_ctrl_phase_counter.sv
// Up-counter with synchronous clear, enable and a terminal-count compare.
// The next count is exported so the owner can register decodes of it.
module phase_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] last_i,
    output logic [W-1:0] cnt_o,
    output logic [W-1:0] cnt_d_o,
    output logic         tc_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)     cnt_d = '0;
        else if (en_i) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt_o   = cnt_q;
    assign cnt_d_o = cnt_d;
    assign tc_o    = (cnt_q == last_i);

endmodule

// File: rtl/corelet_ctrl.sv
// Corelet run sequencer: per kernel position loads weights, activations,
// executes, then drains the OFIFO into psum SRAM with accumulate.
module corelet_ctrl
    import corelet_ctrl_pkg::*;
#(
    parameter int row     = 8,
    parameter int col     = 8,
    parameter int len_kij = 9,
    parameter int len_nij = 36,
    parameter int addr_bw = 11,
    parameter int w_base  = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               relu_en,
    input  logic               o_ready,
    input  logic               o_valid,
    output logic [INST_W-1:0]  inst,
    output logic               xmem_cen,
    output logic [addr_bw-1:0] xmem_addr,
    output logic               pmem_rd,
    output logic               pmem_wr,
    output logic [addr_bw-1:0] pmem_raddr,
    output logic [addr_bw-1:0] pmem_waddr,
    output logic               psum_clr,
    output logic               busy,
    output logic               done
);

    localparam int PMAX = (col > row) ? ((col > len_nij) ? col : len_nij)
                                      : ((row > len_nij) ? row : len_nij);
    localparam int PW   = $clog2(PMAX + 1);
    localparam int KW   = $clog2(len_kij + 1);

    state_e              state_q, state_d;
    logic [PW-1:0]       ph_cnt, ph_nxt, ph_last;
    logic                ph_clr, ph_en, ph_tc;
    logic [KW-1:0]       kij_cnt, kij_nxt;
    logic                kij_clr, kij_en, kij_tc;
    logic                relu_q, rd_fire;
    logic [INST_W-1:0]   inst_q, inst_d;
    logic                cen_q, cen_d, clr_q, clr_d, busy_q, busy_d, done_q, done_d;
    logic                pmem_wr_q;
    logic [addr_bw-1:0]  xaddr_q, xaddr_d, raddr_q, raddr_d, waddr_q, w_addr;
    logic                unused_ready;

    assign unused_ready = o_ready;

    phase_counter #(.W(PW)) u_phase (
        .clk(clk), .reset(reset), .clr_i(ph_clr), .en_i(ph_en),
        .last_i(ph_last), .cnt_o(ph_cnt), .cnt_d_o(ph_nxt), .tc_o(ph_tc)
    );

    phase_counter #(.W(KW)) u_kij (
        .clk(clk), .reset(reset), .clr_i(kij_clr), .en_i(kij_en),
        .last_i(KW'(len_kij - 1)), .cnt_o(kij_cnt), .cnt_d_o(kij_nxt), .tc_o(kij_tc)
    );

    // OFIFO pops track o_valid combinationally; the final DRAIN cycle only retires the last write.
    assign rd_fire = (state_q == DRAIN) && o_valid && (ph_cnt < PW'(len_nij));

    always_comb begin
        ph_last = '0;
        case (state_q)
            W_LOAD:  ph_last = PW'(col);
            K_LOAD:  ph_last = PW'(col - 1);
            K_FLUSH: ph_last = PW'(row - 1);
            A_LOAD:  ph_last = PW'(len_nij);
            EXEC:    ph_last = PW'(len_nij - 1);
            DRAIN:   ph_last = PW'(len_nij);
            default: ph_last = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = W_LOAD;
            W_LOAD:  if (ph_tc) state_d = K_LOAD;
            K_LOAD:  if (ph_tc) state_d = K_FLUSH;
            K_FLUSH: if (ph_tc) state_d = A_LOAD;
            A_LOAD:  if (ph_tc) state_d = EXEC;
            EXEC:    if (ph_tc) state_d = DRAIN;
            DRAIN:   if (ph_tc) state_d = NEXT;
            NEXT:    state_d = kij_tc ? IDLE : W_LOAD;
            default: state_d = IDLE;
        endcase
    end

    assign ph_clr  = (state_d != state_q) || (state_q == IDLE);
    assign ph_en   = (state_q == DRAIN) ? rd_fire : 1'b1;
    assign kij_clr = (state_q == IDLE);
    assign kij_en  = (state_q == NEXT);

    assign w_addr = addr_bw'(w_base) + addr_bw'(kij_nxt) * addr_bw'(col) + addr_bw'(ph_nxt);

    // Outputs are decoded from next-cycle state/counters so they land registered.
    // kij only moves when leaving NEXT, so kij_cnt is already the next value in DRAIN/NEXT.
    always_comb begin
        inst_d  = '0;
        cen_d   = 1'b1;
        xaddr_d = '0;
        raddr_d = '0;
        clr_d   = 1'b0;
        done_d  = 1'b0;
        busy_d  = (state_d != IDLE);
        case (state_d)
            W_LOAD: begin
                inst_d[I_L0WR] = (ph_nxt != '0);
                if (ph_nxt < PW'(col)) begin
                    cen_d   = 1'b0;
                    xaddr_d = w_addr;
                end
            end
            K_LOAD: begin
                inst_d[I_L0RD]  = 1'b1;
                inst_d[I_KLOAD] = 1'b1;
            end
            A_LOAD: begin
                inst_d[I_L0WR] = (ph_nxt != '0);
                if (ph_nxt < PW'(len_nij)) begin
                    cen_d   = 1'b0;
                    xaddr_d = addr_bw'(ph_nxt);
                end
            end
            EXEC: begin
                inst_d[I_L0RD] = 1'b1;
                inst_d[I_EXEC] = 1'b1;
            end
            DRAIN: begin
                inst_d[I_ACC]  = 1'b1;
                inst_d[I_RELU] = relu_q && (kij_cnt == KW'(len_kij - 1));
                clr_d          = (kij_cnt == '0);
                if (ph_nxt < PW'(len_nij)) raddr_d = addr_bw'(ph_nxt);
            end
            NEXT:    done_d = (kij_cnt == KW'(len_kij - 1));
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            relu_q    <= 1'b0;
            inst_q    <= '0;
            cen_q     <= 1'b1;
            xaddr_q   <= '0;
            raddr_q   <= '0;
            waddr_q   <= '0;
            pmem_wr_q <= 1'b0;
            clr_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            if (state_q == IDLE && start) relu_q <= relu_en;
            inst_q    <= inst_d;
            cen_q     <= cen_d;
            xaddr_q   <= xaddr_d;
            raddr_q   <= raddr_d;
            pmem_wr_q <= rd_fire;
            if (rd_fire) waddr_q <= raddr_q;
            clr_q     <= clr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        inst         = inst_q;
        inst[I_OFRD] = rd_fire;
    end

    assign xmem_cen   = cen_q;
    assign xmem_addr  = xaddr_q;
    assign pmem_rd    = rd_fire;
    assign pmem_wr    = pmem_wr_q;
    assign pmem_raddr = raddr_q;
    assign pmem_waddr = waddr_q;
    assign psum_clr   = clr_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_corelet_ctrl.sv
// Directed bench for corelet_ctrl: full runs, drain stalls, ReLU window,
// psum clear window, mid-run reset and start-while-busy.
module tb_corelet_ctrl;
    import corelet_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset, start, relu_en, o_ready, o_valid;
    logic [8:0]  inst;
    logic        xmem_cen, pmem_rd, pmem_wr, psum_clr, busy, done;
    logic [10:0] xmem_addr, pmem_raddr, pmem_waddr;

    corelet_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .relu_en(relu_en),
        .o_ready(o_ready), .o_valid(o_valid), .inst(inst),
        .xmem_cen(xmem_cen), .xmem_addr(xmem_addr), .pmem_rd(pmem_rd),
        .pmem_wr(pmem_wr), .pmem_raddr(pmem_raddr), .pmem_waddr(pmem_waddr),
        .psum_clr(psum_clr), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_fail = 0;
    logic [3:0] ov_pat = 4'b1001;

    int r_busy, r_wr, r_rd, r_xr, r_done, r_done_cyc, r_end_cyc, r_kload, r_exec, r_l0rd;
    int r_relu_cyc, r_clr_cyc, r_drain_idx, r_stall_cyc, r_vnord, r_timeout, r_glitch;
    int r_err_inst, r_err_x, r_err_l0wr, r_err_clr, r_err_relu, r_err_rd, r_err_stall;
    int r_err_raddr, r_err_waddr, r_err_wlag;
    logic [10:0] r_first_xaddr;

    task automatic do_run(input bit relu, input bit toggle, input bit glitch);
        bit prev_xrd, prev_rd, prev_acc, ended;
        logic [10:0] prev_raddr, exp_x;
        int g, k;
        r_busy = 0; r_wr = 0; r_rd = 0; r_xr = 0; r_done = 0; r_done_cyc = -100; r_end_cyc = 0;
        r_kload = 0; r_exec = 0; r_l0rd = 0; r_relu_cyc = 0; r_clr_cyc = 0; r_drain_idx = -1;
        r_stall_cyc = 0; r_vnord = 0; r_timeout = 0; r_glitch = 0;
        r_err_inst = 0; r_err_x = 0; r_err_l0wr = 0; r_err_clr = 0; r_err_relu = 0; r_err_rd = 0;
        r_err_stall = 0; r_err_raddr = 0; r_err_waddr = 0; r_err_wlag = 0; r_first_xaddr = '1;
        prev_xrd = 0; prev_rd = 0; prev_acc = 0; prev_raddr = '0; ended = 0;
        @(posedge clk); #2; relu_en = relu; start = 1'b1; o_valid = 1'b1;
        @(posedge clk); #2; start = 1'b0; relu_en = 1'b0;
        for (int cyc = 0; cyc < 4000 && !ended; cyc++) begin
            o_valid = toggle ? ov_pat[cyc % 4] : 1'b1;
            start   = glitch && (r_xr == 20);
            if (start) r_glitch++;
            #1;
            if (!busy) begin
                ended = 1; r_end_cyc = cyc;
            end else begin
                r_busy++;
                if (inst[5:4] != 2'b00) r_err_inst++;
                if (int'(inst[I_L0WR]) + int'(inst[I_L0RD]) + int'(inst[I_OFRD]) > 1) r_err_inst++;
                if (inst[I_L0RD] !== (inst[I_KLOAD] | inst[I_EXEC])) r_err_inst++;
                if (!xmem_cen) begin
                    g = r_xr % 44; k = r_xr / 44;
                    exp_x = (g < 8) ? 11'(64 + k * 8 + g) : 11'(g - 8);
                    if (xmem_addr !== exp_x) r_err_x++;
                    if (r_xr == 0) r_first_xaddr = xmem_addr;
                    r_xr++;
                end
                if (inst[I_L0WR] !== prev_xrd) r_err_l0wr++;
                prev_xrd = !xmem_cen;
                if (inst[I_KLOAD]) r_kload++;
                if (inst[I_EXEC]) r_exec++;
                if (inst[I_L0RD]) r_l0rd++;
                if (inst[I_ACC] && !prev_acc) r_drain_idx++;
                prev_acc = inst[I_ACC];
                if (psum_clr !== (inst[I_ACC] && r_drain_idx == 0)) r_err_clr++;
                if (psum_clr) r_clr_cyc++;
                if (inst[I_RELU] !== (relu && inst[I_ACC] && r_drain_idx == 8)) r_err_relu++;
                if (inst[I_RELU]) r_relu_cyc++;
                if (pmem_rd !== inst[I_OFRD] || (inst[I_OFRD] && !inst[I_ACC])) r_err_rd++;
                if (pmem_rd && !o_valid) r_err_stall++;
                if (inst[I_ACC] && !o_valid) r_stall_cyc++;
                if (inst[I_ACC] && o_valid && !pmem_rd) r_vnord++;
                if (pmem_rd) begin
                    if (pmem_raddr !== 11'(r_rd % 36)) r_err_raddr++;
                    r_rd++;
                end
                if (pmem_wr !== prev_rd) r_err_wlag++;
                if (pmem_wr) begin
                    if (pmem_waddr !== prev_raddr) r_err_wlag++;
                    if (pmem_waddr !== 11'(r_wr % 36)) r_err_waddr++;
                    r_wr++;
                end
                prev_rd = pmem_rd; prev_raddr = pmem_raddr;
                if (done) begin r_done++; r_done_cyc = cyc; end
                @(posedge clk); #2;
            end
        end
        start = 1'b0; o_valid = 1'b0;
        if (!ended) r_timeout = 1;
    endtask

    task automatic test_reset;
        reset = 1'b0; start = 1'b0; relu_en = 1'b0; o_ready = 1'b1; o_valid = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        n_checks++; if (inst !== 9'h000) begin n_fail++; $display("FAIL reset_inst: got %h expected 000", inst); end
        n_checks++; if (xmem_cen !== 1'b1) begin n_fail++; $display("FAIL reset_cen: got %b expected 1", xmem_cen); end
        n_checks++; if (xmem_addr !== 11'd0) begin n_fail++; $display("FAIL reset_xaddr: got %0d expected 0", xmem_addr); end
        n_checks++; if ({pmem_rd, pmem_wr} !== 2'b00) begin n_fail++; $display("FAIL reset_pmem_strobes: got %b expected 00", {pmem_rd, pmem_wr}); end
        n_checks++; if ({pmem_raddr, pmem_waddr} !== 22'd0) begin n_fail++; $display("FAIL reset_paddr: got %0d/%0d expected 0/0", pmem_raddr, pmem_waddr); end
        n_checks++; if ({psum_clr, busy, done} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {psum_clr, busy, done}); end
        @(posedge clk); #2; reset = 1'b1; o_valid = 1'b0;
        @(posedge clk); #3;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_full_run;
        do_run(1'b0, 1'b0, 1'b0);
        n_checks++; if (r_timeout != 0) begin n_fail++; $display("FAIL full_timeout: got %0d expected 0", r_timeout); end
        n_checks++; if (r_wr != 324) begin n_fail++; $display("FAIL full_writes: got %0d expected 324", r_wr); end
        n_checks++; if (r_rd != 324) begin n_fail++; $display("FAIL full_reads: got %0d expected 324", r_rd); end
        n_checks++; if (r_done != 1) begin n_fail++; $display("FAIL full_done_count: got %0d expected 1", r_done); end
        n_checks++; if (r_end_cyc - r_done_cyc != 1) begin n_fail++; $display("FAIL full_busy_after_done: got gap %0d expected 1", r_end_cyc - r_done_cyc); end
        n_checks++; if (r_busy != 1224) begin n_fail++; $display("FAIL full_busy_cycles: got %0d expected 1224", r_busy); end
        n_checks++; if (r_xr != 396 || r_err_x != 0) begin n_fail++; $display("FAIL full_xmem: got %0d reads %0d bad expected 396/0", r_xr, r_err_x); end
        n_checks++; if (r_err_l0wr != 0) begin n_fail++; $display("FAIL full_l0wr_lag: got %0d bad expected 0", r_err_l0wr); end
        n_checks++; if (r_kload != 72 || r_exec != 324 || r_l0rd != 396) begin n_fail++; $display("FAIL full_phase_lengths: got %0d/%0d/%0d expected 72/324/396", r_kload, r_exec, r_l0rd); end
        n_checks++; if (r_err_inst != 0) begin n_fail++; $display("FAIL full_inst_exclusive: got %0d bad expected 0", r_err_inst); end
        n_checks++; if (r_err_raddr + r_err_waddr + r_err_wlag + r_err_rd != 0) begin n_fail++; $display("FAIL full_pmem_addr: got %0d bad expected 0", r_err_raddr + r_err_waddr + r_err_wlag + r_err_rd); end
        n_checks++; if (r_vnord != 9) begin n_fail++; $display("FAIL full_drain_tail: got %0d expected 9", r_vnord); end
        n_checks++; if (r_relu_cyc != 0) begin n_fail++; $display("FAIL full_relu_off: got %0d expected 0", r_relu_cyc); end
    endtask

    task automatic test_psum_clr;
        do_run(1'b0, 1'b0, 1'b0);
        n_checks++; if (r_drain_idx != 8) begin n_fail++; $display("FAIL clr_drain_count: got %0d expected 8", r_drain_idx); end
        n_checks++; if (r_err_clr != 0) begin n_fail++; $display("FAIL clr_window: got %0d bad expected 0", r_err_clr); end
        n_checks++; if (r_clr_cyc != 37) begin n_fail++; $display("FAIL clr_cycles: got %0d expected 37", r_clr_cyc); end
    endtask

    task automatic test_drain_stall;
        do_run(1'b0, 1'b1, 1'b0);
        n_checks++; if (r_timeout != 0) begin n_fail++; $display("FAIL stall_timeout: got %0d expected 0", r_timeout); end
        n_checks++; if (r_stall_cyc == 0) begin n_fail++; $display("FAIL stall_exercised: got %0d expected >0", r_stall_cyc); end
        n_checks++; if (r_err_stall != 0 || r_err_rd != 0) begin n_fail++; $display("FAIL stall_strobes: got %0d/%0d expected 0/0", r_err_stall, r_err_rd); end
        n_checks++; if (r_err_wlag != 0) begin n_fail++; $display("FAIL stall_wr_lag: got %0d expected 0", r_err_wlag); end
        n_checks++; if (r_err_raddr + r_err_waddr != 0) begin n_fail++; $display("FAIL stall_addr_seq: got %0d bad expected 0", r_err_raddr + r_err_waddr); end
        n_checks++; if (r_wr != 324 || r_done != 1) begin n_fail++; $display("FAIL stall_totals: got %0d writes %0d done expected 324/1", r_wr, r_done); end
    endtask

    task automatic test_relu;
        do_run(1'b1, 1'b0, 1'b0);
        n_checks++; if (r_err_relu != 0) begin n_fail++; $display("FAIL relu_window: got %0d bad expected 0", r_err_relu); end
        n_checks++; if (r_relu_cyc != 37) begin n_fail++; $display("FAIL relu_cycles: got %0d expected 37", r_relu_cyc); end
    endtask

    task automatic test_start_while_busy;
        do_run(1'b1, 1'b0, 1'b1);
        n_checks++; if (r_glitch != 1) begin n_fail++; $display("FAIL glitch_applied: got %0d expected 1", r_glitch); end
        n_checks++; if (r_busy != 1224 || r_wr != 324 || r_xr != 396) begin n_fail++; $display("FAIL glitch_sequence: got %0d/%0d/%0d expected 1224/324/396", r_busy, r_wr, r_xr); end
        n_checks++; if (r_done != 1 || r_err_x != 0) begin n_fail++; $display("FAIL glitch_done_addr: got %0d/%0d expected 1/0", r_done, r_err_x); end
        n_checks++; if (r_relu_cyc != 37) begin n_fail++; $display("FAIL glitch_relu_kept: got %0d expected 37", r_relu_cyc); end
    endtask

    task automatic test_reset_mid_run;
        int ex, drains, idle_bad;
        bit hit, prev_acc;
        ex = 0; drains = 0; hit = 0; prev_acc = 0; idle_bad = 0;
        @(posedge clk); #2; start = 1'b1; o_valid = 1'b1;
        @(posedge clk); #2; start = 1'b0;
        for (int cyc = 0; cyc < 2000 && !hit; cyc++) begin
            #1;
            if (inst[I_ACC] && !prev_acc) drains++;
            prev_acc = inst[I_ACC];
            if (inst[I_EXEC]) ex++;
            if (ex == 3 * 36 + 10) hit = 1;
            else begin @(posedge clk); #2; end
        end
        n_checks++; if (!hit || drains != 3) begin n_fail++; $display("FAIL abort_reached_kij3_exec: got hit=%0d drains=%0d expected 1/3", hit, drains); end
        reset = 1'b0;
        #1;
        n_checks++; if (inst !== 9'h000 || xmem_cen !== 1'b1 || xmem_addr !== 11'd0) begin n_fail++; $display("FAIL abort_xmem_idle: got %h/%b/%0d expected 000/1/0", inst, xmem_cen, xmem_addr); end
        n_checks++; if ({pmem_rd, pmem_wr, psum_clr, busy, done} !== 5'b0) begin n_fail++; $display("FAIL abort_flags_idle: got %b expected 00000", {pmem_rd, pmem_wr, psum_clr, busy, done}); end
        n_checks++; if ({pmem_raddr, pmem_waddr} !== 22'd0) begin n_fail++; $display("FAIL abort_paddr_idle: got %0d/%0d expected 0/0", pmem_raddr, pmem_waddr); end
        @(posedge clk); #2; reset = 1'b1;
        repeat (3) begin
            @(posedge clk); #3;
            if (busy !== 1'b0 || xmem_cen !== 1'b1 || pmem_wr !== 1'b0) idle_bad++;
        end
        n_checks++; if (idle_bad != 0) begin n_fail++; $display("FAIL abort_stays_idle: got %0d bad expected 0", idle_bad); end
        do_run(1'b0, 1'b0, 1'b0);
        n_checks++; if (r_first_xaddr !== 11'd64) begin n_fail++; $display("FAIL restart_first_addr: got %0d expected 64", r_first_xaddr); end
        n_checks++; if (r_wr != 324 || r_done != 1 || r_busy != 1224) begin n_fail++; $display("FAIL restart_full_run: got %0d/%0d/%0d expected 324/1/1224", r_wr, r_done, r_busy); end
    endtask

    initial begin
        test_reset;
        test_full_run;
        test_psum_clr;
        test_drain_stall;
        test_relu;
        test_start_while_busy;
        test_reset_mid_run;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/corelet_ctrl.md
CORELET_CTRL -- requirements
Module: corelet_ctrl

Interface
REQ-001 SHALL have parameter row, default 8, PE rows / L0 lanes.
REQ-002 SHALL have parameter col, default 8, PE columns / OFIFO lanes.
REQ-003 SHALL have parameter len_kij, default 9, kernel positions per run.
REQ-004 SHALL have parameter len_nij, default 36, output pixels per kernel position.
REQ-005 SHALL have parameter addr_bw, default 11, SRAM address width.
REQ-006 SHALL have parameter w_base, default 64, xmem base address of weights.
REQ-007 clk  in  1  single clock; all state updates on rising edge.
REQ-008 reset  in  1  asynchronous, active-low reset.
REQ-009 start  in  1  one-cycle pulse that begins a run; ignored while busy=1.
REQ-010 relu_en  in  1  ReLU request, sampled at start.
REQ-011 o_ready  in  1  corelet OFIFO can accept data.
REQ-012 o_valid  in  1  corelet OFIFO holds a readable word.
REQ-013 inst  out  9  corelet command: [8] relu, [7] accumulate, [6] ofifo_rd, [5] ififo_wr (always 0), [4] ififo_rd (always 0), [3] l0_rd, [2] l0_wr, [1] execute, [0] kernel_load.
REQ-014 xmem_cen  out  1  activation/weight SRAM chip enable, active-low.
REQ-015 xmem_addr  out  addr_bw  xmem read address.
REQ-016 pmem_rd  out  1  psum SRAM read strobe.
REQ-017 pmem_wr  out  1  psum SRAM write strobe.
REQ-018 pmem_raddr / pmem_waddr  out  addr_bw each  psum read / write addresses.
REQ-019 psum_clr  out  1  high during kij 0 drain; top forces the sfp pmem operand to zero.
REQ-020 busy  out  1  run in progress.
REQ-021 done  out  1  one-cycle pulse after the final write of a run.

Function
REQ-022 FSM states SHALL be IDLE, W_LOAD, K_LOAD, K_FLUSH, A_LOAD, EXEC, DRAIN, NEXT.
REQ-023 IDLE->W_LOAD on start; kij counter cleared, relu_en latched.
REQ-024 W_LOAD SHALL read xmem w_base+kij*col+i for i=0..col-1, with l0_wr one cycle after each read (1-cycle SRAM latency), col+1 cycles total.
REQ-025 K_LOAD SHALL assert l0_rd and inst[0] for exactly col cycles; K_FLUSH SHALL hold inst=0 for row cycles.
REQ-026 A_LOAD SHALL read xmem 0..len_nij-1 with l0_wr lagging by one cycle, len_nij+1 cycles total.
REQ-027 EXEC SHALL assert l0_rd and inst[1] for exactly len_nij cycles.
REQ-028 In DRAIN, inst[6] SHALL equal o_valid, inst[7] SHALL be 1, and each read SHALL assert pmem_rd at address n (n=0..len_nij-1) in the same cycle.
REQ-029 pmem_wr SHALL fire one cycle after each OFIFO read, with pmem_waddr equal to that read's pmem_raddr.
REQ-030 If o_valid=0 the drain SHALL stall with no read/write strobes, no counter advance, and no timeout.
REQ-031 DRAIN->NEXT after len_nij writes; NEXT SHALL increment kij, going to W_LOAD if kij<len_kij-1, else IDLE with done=1.
REQ-032 inst[8] SHALL equal latched relu_en only during the final kij's DRAIN.
REQ-033 busy SHALL be 1 in every state except IDLE; start while busy SHALL be ignored.
REQ-034 Only one of l0_wr, l0_rd, ofifo_rd group SHALL be active per state; inst[5:4] SHALL always be 0.
REQ-035 Counters SHALL be sized from parameters with no wrap inside a phase; addresses SHALL be computed in addr_bw bits.

Reset
REQ-036 Async reset (reset=0) SHALL force IDLE, clear all counters, and set inst=0, xmem_cen=1, pmem_rd=pmem_wr=0, addresses=0, psum_clr=busy=done=0.
REQ-037 Reset mid-run SHALL abort with no further strobes; the next start SHALL begin from kij 0.

Structure
REQ-038 The shared package SHALL hold the inst bit-index constants and the FSM state enum, for reuse by the corelet and its bench.
REQ-039 One sub-module, phase_counter (load/terminal-count counter), SHALL be used for all phase lengths.

Verification
REQ-040 Test: reset, start, o_valid held 1 -> 9 kij iterations, 324 pmem writes, done exactly once, busy low after.
REQ-041 Test: kij 0 drain -> psum_clr=1 and inst[7]=1 throughout; psum_clr=0 for kij 1..8.
REQ-042 Test: o_valid toggled 1,0,0,1 during DRAIN -> read/write strobes only on valid cycles, waddr=raddr delayed by 1, addresses contiguous 0..35.
REQ-043 Test: relu_en=1 at start -> inst[8]=1 only during kij 8 DRAIN.
REQ-044 Test: reset asserted during EXEC of kij 3 -> all outputs idle values immediately; restart -> W_LOAD reads address 64.
REQ-045 Test: start pulsed during A_LOAD -> no effect on sequence or counts.
